// File: rtl/rom_scan_controller_if.sv
// Output word stream of the ROM scan controller: sampled word plus its address on valid/ready.
interface rom_scan_controller_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 9
);
  logic [DATA_WIDTH-1:0]    out_data;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output out_data,
    output out_address,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_address,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/rom_scan_controller.sv
// Reads every word of a 556PT5/556PT4-class ROM in address order and streams it out.
// Optional running checksum of sampled words when ROM_SCAN_CHECKSUM_EN is defined.
module rom_scan_controller #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DATA_WIDTH-1:0]    rom_data_in,
  output logic [3:0]               rom_operation,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  rom_scan_controller_if.master    out_if,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    checksum
);

  localparam logic [7:0]               CntReload = 8'(ACCESS_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LastAddr  = '1;
  localparam logic [3:0]               OpRead    = 4'b1100;
  localparam logic [3:0]               OpOff     = 4'b0000;

  typedef enum logic [1:0] {StIdle, StSetup, StPresent, StDone} state_e;

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [3:0]               op_q, op_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    valid_d    = valid_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        op_d = OpOff;
        if (start && !abort) begin
          state_d = StSetup;
          addr_d  = '0;
          op_d    = OpRead;
          cnt_d   = CntReload;
        end
      end
      StSetup: begin
        if (cnt_q == 8'd0) begin
          out_data_d = rom_data_in;
          out_addr_d = addr_q;
          valid_d    = 1'b1;
          state_d    = StPresent;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StPresent: begin
        if (valid_q && out_if.out_ready) begin
          valid_d = 1'b0;
          if (addr_q == LastAddr) begin
            state_d = StDone;
            op_d    = OpOff;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = CntReload;
            state_d = StSetup;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything decided above, including a pending done pulse.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      op_d    = OpOff;
      addr_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      op_q       <= OpOff;
      addr_q     <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef ROM_SCAN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] ck_q, ck_d;

  always_comb begin
    ck_d = ck_q;
    if (state_q == StIdle && start && !abort) begin
      ck_d = '0;
    end else if (state_q == StSetup && !abort && cnt_q == 8'd0) begin
      ck_d = ck_q + rom_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ck_q <= '0;
    end else begin
      ck_q <= ck_d;
    end
  end

  assign checksum = ck_q;
`else
  assign checksum = '0;
`endif

  assign rom_operation      = op_q;
  assign rom_address        = addr_q;
  assign out_if.out_data    = out_data_q;
  assign out_if.out_address = out_addr_q;
  assign out_if.out_valid   = valid_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_rom_scan_controller.sv
// Directed-plus-random bench for rom_scan_controller against an address-sequence reference model.
module tb_rom_scan_controller;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned ACC = 2;
  localparam int          NW  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [DW-1:0] rom_data_in;
  logic [3:0]    rom_operation;
  logic [AW-1:0] rom_address;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  int vectors = 0;
  int errors  = 0;

  rom_scan_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) sif ();

  rom_scan_controller #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .ACCESS_CYCLES(ACC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .rom_data_in  (rom_data_in),
    .rom_operation(rom_operation),
    .rom_address  (rom_address),
    .out_if       (sif),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  assign rom_data_in = DW'(rom_address) ^ 8'hA5;

  function automatic logic [DW-1:0] rom_word(input int a);
    logic [DW-1:0] w;
    w = DW'(a) ^ 8'hA5;
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_checksum(input logic [DW-1:0] sum);
`ifdef ROM_SCAN_CHECKSUM_EN
    return sum;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({rom_operation, rom_address, sif.out_data, sif.out_address, sif.out_valid,
                busy, done, checksum});
  endfunction

  // One scan from IDLE. Model: words must appear in address order 0..NW-1, each equal to
  // rom_word(address), held stable until accepted, with optional stall/abort/reset events.
  task automatic scan(input int ready_pct, input int stall_addr, input int abort_addr,
                      input int reset_addr, input bit poke_start);
    int            cyc, nxt, last_seen, stall_left;
    bit            stalled, prev_valid, finished, strict;
    logic [DW-1:0] prev_data, sum;
    logic [AW-1:0] prev_addr;
    nxt = 0; last_seen = 0; stall_left = 0; cyc = 0;
    stalled = 0; prev_valid = 0; finished = 0; sum = '0;
    prev_data = '0; prev_addr = '0;
    strict = (ready_pct == 100) && (stall_addr < 0) && !poke_start;
    start = 1'b1;
    sif.out_ready = 1'b0;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done) begin
        chk("done_words", nxt, NW);
        chk("done_op", rom_operation, 4'b0000);
        chk("done_checksum", checksum, exp_checksum(sum));
        start = 1'b0;
        sif.out_ready = 1'b0;
        @(negedge clk);
        chk("post_done", {done, busy, sif.out_valid, rom_address}, 0);
        chk("checksum_hold", checksum, exp_checksum(sum));
        finished = 1;
      end else begin
        chk("busy", busy, 1);
        chk("op_read", rom_operation, 4'b1100);
        if (sif.out_valid) begin
          if (!prev_valid) begin
            chk("addr_seq", sif.out_address, nxt);
            if (nxt == 0) chk("first_latency", cyc, ACC + 1);
            else if (strict) chk("interval", cyc - last_seen, ACC + 1);
            last_seen = cyc;
            sum = sum + rom_word(nxt);
          end else begin
            chk("hold_data", sif.out_data, prev_data);
            chk("hold_addr", sif.out_address, prev_addr);
          end
          chk("data", sif.out_data, rom_word(int'(sif.out_address)));
          chk("rom_addr_stable", rom_address, sif.out_address);
          if (int'(sif.out_address) == abort_addr) begin
            abort = 1'b1;
            start = 1'b1;
            sif.out_ready = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            chk("abort_state", {busy, done, sif.out_valid, rom_operation, rom_address}, 0);
            repeat (4) begin
              @(negedge clk);
              chk("abort_no_done", {done, busy}, 0);
            end
            finished = 1;
          end else if (int'(sif.out_address) == reset_addr) begin
            reset_n = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk("reset_mid_scan", all_outputs(), 0);
            reset_n = 1'b1;
            @(negedge clk);
            chk("reset_idle", all_outputs(), 0);
            finished = 1;
          end else begin
            if (int'(sif.out_address) == stall_addr && !stalled) begin
              stalled = 1;
              stall_left = 20;
            end
            if (stall_left > 0) begin
              sif.out_ready = 1'b0;
              stall_left--;
            end else begin
              sif.out_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (sif.out_ready) nxt++;
          end
        end else begin
          sif.out_ready = ($urandom_range(0, 99) < ready_pct);
        end
        prev_valid = sif.out_valid && !sif.out_ready;
        prev_data  = sif.out_data;
        prev_addr  = sif.out_address;
      end
    end
    if (!finished) chk("scan_timeout", 0, 1);
    sif.out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", all_outputs(), 0);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle", all_outputs(), 0);
    end

    scan(100, -1, -1, -1, 1'b0);  // full scan, ready tied high
    scan(100, 3, -1, -1, 1'b0);   // 20-cycle backpressure at address 3
    scan(100, -1, 5, -1, 1'b0);   // abort at address 5 with ready high
    scan(60, -1, -1, -1, 1'b1);   // random ready, start pokes mid-scan
    scan(70, -1, -1, 4, 1'b1);    // reset mid-scan
    scan(100, -1, -1, -1, 1'b0);  // clean scan after reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
